// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch entry pairs an instruction with the word address it came from.
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W = 5;
  localparam int IFU_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STOP  = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_DATA_W-1:0] instr;
    logic [IFU_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched words; flush empties it in one cycle.
// The head is forced to zero while empty so stale storage never leaks out.
module prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push  = push & ~flush;
  assign w_do_pop   = pop & (r_count != '0) & ~flush;
  assign count      = r_count;
  assign head_valid = (r_count != '0);
  assign head_data  = head_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !rst) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: one outstanding read at a time, words land in the prefetch FIFO.
// Redirects flush the FIFO; a response owed to a cancelled request is dropped via r_discard.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W     = IFU_ADDR_W,
  parameter int DATA_W     = IFU_DATA_W,
  parameter int RESET_PC   = 0,
  parameter int LAST_PC    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready,
  output logic              done
);

  localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_PC);
  localparam int ENTRY_W = DATA_W + ADDR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_req_pc, w_req_pc_nxt;
  logic              r_discard, w_discard_nxt;
  logic              r_imem_req, w_req_nxt;
  logic [ADDR_W-1:0] r_imem_addr, w_addr_nxt;
  logic              r_done, w_done_nxt;
  logic              w_push, w_pop;
  logic [CNT_W-1:0]  w_count, w_count_nxt;
  logic [ENTRY_W-1:0] w_head;

  assign w_pop       = dec_valid & dec_ready;
  assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_done_nxt  = (w_state_nxt == ST_STOP) && (w_count_nxt == '0);

  // Next-state and request decision; any redirect overrides the normal flow.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_req_pc_nxt  = r_req_pc;
    w_discard_nxt = r_discard;
    w_req_nxt     = 1'b0;
    w_addr_nxt    = r_imem_addr;
    w_push        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        // A stale response owed from before a reset must drain before we issue again.
        if (r_discard && imem_valid) w_discard_nxt = 1'b0;
        else                         w_discard_nxt = r_discard;
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end else if (!r_discard && (w_count < CNT_W'(FIFO_DEPTH))) begin
          w_req_nxt    = 1'b1;
          w_addr_nxt   = r_pc;
          w_req_pc_nxt = r_pc;
          w_state_nxt  = ST_WAIT;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          if (redirect_valid) begin
            w_pc_nxt      = redirect_pc;
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_FETCH;
          end else if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_FETCH;
          end else begin
            w_push = 1'b1;
            if (r_req_pc == LAST_A) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_pc_nxt    = r_req_pc + 1'b1;
              w_state_nxt = ST_FETCH;
            end
          end
        end else if (redirect_valid) begin
          w_pc_nxt      = redirect_pc;
          w_discard_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_STOP: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // State and registered outputs; a reset mid-request remembers that a response is still owed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_A;
      r_req_pc    <= '0;
      r_discard   <= ((r_state == ST_WAIT) || r_discard) && !imem_valid;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_discard   <= w_discard_nxt;
      r_imem_req  <= w_req_nxt;
      r_imem_addr <= w_addr_nxt;
      r_done      <= w_done_nxt;
    end
  end

  prefetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({imem_instr, r_req_pc}),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .count     (w_count),
    .head_valid(dec_valid),
    .head_data (w_head)
  );

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign dec_instr = w_head[ENTRY_W-1:ADDR_W];
  assign dec_pc    = w_head[ADDR_W-1:0];
  assign done      = r_done;

endmodule
